// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } sar_state_e;

    localparam int SAR_W_DEF   = 4;
    localparam int SAR_MSB_DEF = SAR_W_DEF - 1;

    // Single trial bit at position i; callers truncate to their probe width.
    function automatic logic [31:0] trial_mask(input int unsigned i);
        return 32'd1 << i;
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator for a combinational comparator: drives probe, reads
// gt/lt/eq, and recovers the comparator's hidden A operand MSB first.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter  int W  = SAR_W_DEF,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cmp_gt,
    input  logic          cmp_lt,
    input  logic          cmp_eq,
    output logic [W-1:0]  probe,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          hit,
    output logic          err,
    output logic [CW-1:0] steps
);

    localparam int MSB = W - 1;

    sar_state_e      state_r;
    logic [CW-1:0]   idx_r;
    logic [W-1:0]    probe_r;
    logic            busy_r;
    logic            done_r;
    logic [W-1:0]    result_r;
    logic            hit_r;
    logic            err_r;
    logic [CW-1:0]   steps_r;

    logic            resp_ok_s;
    logic [W-1:0]    cur_mask_s;
    logic [W-1:0]    next_mask_s;
    logic [W-1:0]    new_val_s;
    logic [W-1:0]    next_probe_s;

    // Decode the comparator response and form the kept value and next trial.
    always_comb begin
        resp_ok_s    = $onehot({cmp_gt, cmp_lt, cmp_eq});
        cur_mask_s   = W'(trial_mask(32'(idx_r)));
        next_mask_s  = W'(trial_mask(32'(idx_r - CW'(1))));
        new_val_s    = probe_r;
        if (cmp_gt) begin
            new_val_s = probe_r;
        end else begin
            new_val_s = probe_r & ~cur_mask_s;
        end
        next_probe_s = new_val_s | next_mask_s;
    end

    // Search FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            idx_r    <= CW'(0);
            probe_r  <= W'(0);
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= W'(0);
            hit_r    <= 1'b0;
            err_r    <= 1'b0;
            steps_r  <= CW'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        result_r <= W'(0);
                        hit_r    <= 1'b0;
                        err_r    <= 1'b0;
                        steps_r  <= CW'(0);
                        idx_r    <= CW'(MSB);
                        probe_r  <= W'(trial_mask(32'(MSB)));
                        busy_r   <= 1'b1;
                        state_r  <= TEST;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                TEST: begin
                    steps_r <= steps_r + CW'(1);
                    if (!resp_ok_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else if (cmp_eq) begin
                        result_r <= probe_r;
                        hit_r    <= 1'b1;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        result_r <= new_val_s;
                        if (idx_r == CW'(0)) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            idx_r   <= idx_r - CW'(1);
                            probe_r <= next_probe_s;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign probe  = probe_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign hit    = hit_r;
    assign err    = err_r;
    assign steps  = steps_r;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Closed-loop bench: a comparator model answers the probes and each search is
// checked against a plain binary-search reference computed per target.
module tb_sar_search_ctrl;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cmp_gt, cmp_lt, cmp_eq;
    logic [W-1:0]  probe;
    logic          busy, done, hit, err;
    logic [W-1:0]  result;
    logic [CW-1:0] steps;

    logic [W-1:0]  target;
    logic          bad_resp;
    int            n_assert = 0;
    int            n_fail   = 0;

    sar_search_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .probe(probe), .busy(busy), .done(done), .result(result),
        .hit(hit), .err(err), .steps(steps)
    );

    always #5 clk = ~clk;

    assign cmp_gt = bad_resp ? 1'b1 : (target > probe);
    assign cmp_lt = bad_resp ? 1'b1 : (target < probe);
    assign cmp_eq = bad_resp ? 1'b0 : (target == probe);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: probes issued by an MSB-first search, with early exit on equality.
    task automatic ref_search(input logic [W-1:0] tgt, output int probes[$],
                              output int res, output bit rhit);
        int acc = 0;
        probes = {};
        rhit = 1'b0;
        res = 0;
        for (int b = W - 1; b >= 0; b--) begin
            int p = acc + (1 << b);
            probes.push_back(p);
            if (int'(tgt) == p) begin
                rhit = 1'b1;
                acc = p;
                break;
            end
            if (int'(tgt) > p) acc = p;
        end
        res = acc;
    endtask

    // One complete search; optionally pokes start mid-search and in the DONE cycle.
    task automatic run_search(input logic [W-1:0] tgt, input bit poke_start);
        int  probes[$];
        int  res;
        bit  rhit;
        ref_search(tgt, probes, res, rhit);
        target = tgt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < probes.size(); i++) begin
            chk("busy_in_test", busy, 1);
            chk("probe", probe, probes[i]);
            chk("done_in_test", done, 0);
            start = (poke_start && i == 1) ? 1'b1 : 1'b0;
            tick();
        end
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("result", result, res);
        chk("result_eq_target", result, tgt);
        chk("hit", hit, rhit);
        chk("err", err, 0);
        chk("steps", steps, probes.size());
        start = poke_start;
        tick();
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
        chk("result_held", result, res);
        chk("steps_held", steps, probes.size());
    endtask

    initial begin
        int tgt;
        rst_n = 1'b0;
        start = 1'b0;
        target = '0;
        bad_resp = 1'b0;
        tick();
        tick();
        chk("rst_probe", probe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_hit", hit, 0);
        chk("rst_err", err, 0);
        chk("rst_steps", steps, 0);
        rst_n = 1'b1;
        tick();

        run_search(4'd5, 1'b0);
        run_search(4'd8, 1'b0);
        run_search(4'd0, 1'b0);
        run_search(4'd15, 1'b0);
        run_search(4'd6, 1'b1);
        for (int t = 0; t < 16; t++) run_search(W'(t), 1'b0);
        for (int r = 0; r < 12; r++) run_search(W'($urandom_range(0, 15)), r[0]);

        // Illegal response on the second probe aborts with err.
        tgt = $urandom_range(0, 7);
        target = W'(tgt);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fault_probe1", probe, 8);
        tick();
        bad_resp = 1'b1;
        chk("fault_probe2", probe, 4);
        tick();
        bad_resp = 1'b0;
        chk("fault_done", done, 1);
        chk("fault_err", err, 1);
        chk("fault_hit", hit, 0);
        chk("fault_steps", steps, 2);
        chk("fault_result", result, 0);
        tick();
        chk("fault_done_drop", done, 0);

        // Reset in the third TEST cycle: back to idle, no done pulse.
        target = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_probe3", probe, 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_probe", probe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_steps", steps, 0);
        tick();
        chk("mid_rst_no_done", done, 0);
        tick();
        chk("mid_rst_no_done2", done, 0);
        run_search(4'd11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
